// File: rtl/memory_responder.sv
// memory_responder: word-addressed single-port RAM behind an IDLE/WAIT/ACCESS FSM with
// programmable wait states. Define MEMORY_RESPONDER_ADDR_CHECK_EN to flag out-of-range addresses.
module memory_responder #(
  parameter int BITS        = 32,
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic            Clock,
  input  logic            reset,
  input  logic            Read,
  input  logic            Write,
  input  logic [BITS-1:0] MARVal,
  input  logic [BITS-1:0] MDRVal,
  output logic [BITS-1:0] Mdatain,
  output logic            MemReady,
  output logic            Busy,
  output logic            AddrErr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                 state;
  logic [3:0]             wait_cnt;
  logic [ADDR_BITS-1:0]   addr;
  logic [BITS-1:0]        wdata;
  logic                   op_read;
  logic                   addr_flag;
  logic                   req_flag;
  logic                   err_q;
  logic [BITS-1:0]        ram [0:(1 << ADDR_BITS)-1];

`ifdef MEMORY_RESPONDER_ADDR_CHECK_EN
  assign req_flag = |MARVal[BITS-1:ADDR_BITS];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^MARVal[BITS-1:ADDR_BITS];
  assign req_flag       = 1'b0;
`endif

  assign AddrErr = err_q;

  always_ff @(posedge Clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      addr      <= '0;
      wdata     <= '0;
      op_read   <= 1'b0;
      addr_flag <= 1'b0;
      Mdatain   <= '0;
      MemReady  <= 1'b0;
      Busy      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      MemReady <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Read || Write) begin
            addr      <= MARVal[ADDR_BITS-1:0];
            wdata     <= MDRVal;
            op_read   <= Read;  // read wins a Read/Write collision
            addr_flag <= req_flag;
            Busy      <= 1'b1;
            if (WAIT_STATES == 0) begin
              state <= S_ACCESS;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_ACCESS;
          else                wait_cnt <= wait_cnt - 4'd1;
        end
        S_ACCESS: begin
          if (op_read) Mdatain <= addr_flag ? '0 : ram[addr];
          MemReady <= 1'b1;
          Busy     <= 1'b0;
          err_q    <= addr_flag;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM is never reset; a reset on the access edge cancels the pending write.
  always_ff @(posedge Clock) begin
    if (reset && state == S_ACCESS && !op_read && !addr_flag)
      ram[addr] <= wdata;
  end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (WAIT_STATES 0/1/3) on shared stimulus,
// directed table + hand sequences + random traffic against a transaction-level model.
module tb_memory_responder;
  localparam int N = 3;

  logic        Clock, reset, Read, Write;
  logic [31:0] MARVal, MDRVal;
  logic [31:0] md   [N];
  logic        rdy  [N];
  logic        busy [N];
  logic        err  [N];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    memory_responder #(
      .BITS(32), .ADDR_BITS(9), .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (
      .Clock(Clock), .reset(reset), .Read(Read), .Write(Write),
      .MARVal(MARVal), .MDRVal(MDRVal),
      .Mdatain(md[g]), .MemReady(rdy[g]), .Busy(busy[g]), .AddrErr(err[g])
    );
  end

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

`ifdef MEMORY_RESPONDER_ADDR_CHECK_EN
  localparam bit ACHK = 1'b1;
`else
  localparam bit ACHK = 1'b0;
`endif

  // Transaction-level reference: one pending request with a count of edges left before access.
  int          ws_of   [N] = '{0, 1, 3};
  bit          m_pend  [N];
  int          m_left  [N];
  bit          m_rd    [N];
  int          m_addr  [N];
  logic [31:0] m_data  [N];
  bit          m_flag  [N];
  logic [31:0] m_md    [N];
  bit          m_md_ok [N];
  bit          m_rdy   [N];
  bit          m_busy  [N];
  bit          m_err   [N];
  logic [31:0] mem     [N][512];
  bit          known   [N][512];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      if (!reset) begin
        m_pend[i] = 0; m_md[i] = '0; m_md_ok[i] = 1;
        m_rdy[i] = 0; m_busy[i] = 0; m_err[i] = 0;
      end else begin
        m_rdy[i] = 0; m_err[i] = 0;
        if (m_pend[i]) begin
          if (m_left[i] > 0) m_left[i]--;
          else begin
            m_pend[i] = 0; m_busy[i] = 0; m_rdy[i] = 1; m_err[i] = m_flag[i];
            if (m_rd[i]) begin
              if (m_flag[i]) begin m_md[i] = '0; m_md_ok[i] = 1; end
              else if (known[i][m_addr[i]]) begin m_md[i] = mem[i][m_addr[i]]; m_md_ok[i] = 1; end
              else m_md_ok[i] = 0;
            end else if (!m_flag[i]) begin
              mem[i][m_addr[i]] = m_data[i];
              known[i][m_addr[i]] = 1;
            end
          end
        end else if (Read || Write) begin
          m_pend[i] = 1; m_left[i] = ws_of[i]; m_rd[i] = Read;
          m_addr[i] = int'(MARVal % 512);
          m_data[i] = MDRVal;
          m_flag[i] = ACHK && (MARVal >= 512);
          m_busy[i] = 1;
        end
      end
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < N; i++) begin
      check($sformatf("d%0d MemReady", i), 32'(rdy[i]),  32'(m_rdy[i]));
      check($sformatf("d%0d Busy", i),     32'(busy[i]), 32'(m_busy[i]));
      check($sformatf("d%0d AddrErr", i),  32'(err[i]),  32'(m_err[i]));
      if (m_md_ok[i]) check($sformatf("d%0d Mdatain", i), md[i], m_md[i]);
    end
  endtask

  task automatic step(input bit rst_n, input bit rd, input bit wr,
                      input logic [31:0] mar, input logic [31:0] mdr);
    reset = rst_n; Read = rd; Write = wr; MARVal = mar; MDRVal = mdr;
    @(posedge Clock);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1, 0, 0, 32'h0, 32'h0);
  endtask

  typedef struct {
    bit          rst_n, rd, wr;
    logic [31:0] mar, mdr;
    bit          e_rdy, e_busy;
    logic [31:0] e_md;
  } vec_t;

  function automatic vec_t mk(bit rst_n, bit rd, bit wr, logic [31:0] mar, logic [31:0] mdr,
                              bit e_rdy, bit e_busy, logic [31:0] e_md);
    vec_t v;
    v.rst_n = rst_n; v.rd = rd; v.wr = wr; v.mar = mar; v.mdr = mdr;
    v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_md = e_md;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    // Expected values are for the WAIT_STATES=1 instance.
    tbl.push_back(mk(0, 1, 0, 32'h00, 32'h00,       0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h00, 32'h00,       0, 0, 32'h0));
    tbl.push_back(mk(1, 0, 1, 32'h10, 32'h22,       0, 1, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h55, 32'h00,       0, 1, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h00, 32'h00,       1, 0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h10, 32'h00,       0, 1, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h00, 32'h00,       0, 1, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h00, 32'h00,       1, 0, 32'h22));
    tbl.push_back(mk(1, 0, 0, 32'h00, 32'h00,       0, 0, 32'h22));
    tbl.push_back(mk(1, 0, 1, 32'h11, 32'hA5A5A5A5, 0, 1, 32'h22));
    tbl.push_back(mk(1, 0, 0, 32'h00, 32'h00,       0, 1, 32'h22));
    tbl.push_back(mk(1, 0, 0, 32'h00, 32'h00,       1, 0, 32'h22));
    tbl.push_back(mk(1, 1, 1, 32'h11, 32'h12345678, 0, 1, 32'h22));
    tbl.push_back(mk(1, 0, 0, 32'h00, 32'h00,       0, 1, 32'h22));
    tbl.push_back(mk(1, 0, 0, 32'h00, 32'h00,       1, 0, 32'hA5A5A5A5));
    tbl.push_back(mk(1, 1, 0, 32'h10, 32'h00,       0, 1, 32'hA5A5A5A5));
    tbl.push_back(mk(1, 1, 0, 32'h11, 32'h00,       0, 1, 32'hA5A5A5A5));
    tbl.push_back(mk(1, 1, 0, 32'h11, 32'h00,       1, 0, 32'h22));
    tbl.push_back(mk(1, 1, 0, 32'h11, 32'h00,       0, 1, 32'h22));
    tbl.push_back(mk(1, 0, 0, 32'h00, 32'h00,       0, 1, 32'h22));
    tbl.push_back(mk(1, 0, 0, 32'h00, 32'h00,       1, 0, 32'hA5A5A5A5));

    for (int r = 0; r < tbl.size(); r++) begin
      step(tbl[r].rst_n, tbl[r].rd, tbl[r].wr, tbl[r].mar, tbl[r].mdr);
      check($sformatf("tbl%0d MemReady", r), 32'(rdy[1]),  32'(tbl[r].e_rdy));
      check($sformatf("tbl%0d Busy", r),     32'(busy[1]), 32'(tbl[r].e_busy));
      check($sformatf("tbl%0d Mdatain", r),  md[1],        tbl[r].e_md);
    end

    // Clean start with known contents at 0x10 / 0x11 in every instance
    step(0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 1, 32'h10, 32'h22);       idle(5);
    step(1, 0, 1, 32'h11, 32'hA5A5A5A5); idle(5);

    // Back-to-back reads, zero wait states, strobe dropped on MemReady
    step(1, 1, 0, 32'h10, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    check("b2b rdy1", 32'(rdy[0]), 32'd1);
    check("b2b md1",  md[0],       32'h22);
    step(1, 1, 0, 32'h11, 32'h0);
    check("b2b gap",  32'(rdy[0]), 32'd0);
    step(1, 0, 0, 32'h0, 32'h0);
    check("b2b rdy2", 32'(rdy[0]), 32'd1);
    check("b2b md2",  md[0],       32'hA5A5A5A5);
    idle(5);

    // Address/strobe changes while busy are ignored (WAIT_STATES=3)
    step(1, 1, 0, 32'h10, 32'h0);
    step(1, 0, 1, 32'h11, 32'hDEADBEEF);
    idle(2);
    step(1, 0, 0, 32'h11, 32'h0);
    check("mid rdy", 32'(rdy[2]), 32'd1);
    check("mid md",  md[2],       32'h22);
    idle(3);
    step(1, 1, 1, 32'h11, 32'h55);
    idle(3);
    step(1, 0, 0, 32'h0, 32'h0);
    check("coll rdy", 32'(rdy[2]), 32'd1);
    check("coll md",  md[2],       32'hA5A5A5A5);
    idle(3);
    step(1, 1, 0, 32'h11, 32'h0);
    idle(3);
    step(1, 0, 0, 32'h0, 32'h0);
    check("nowrite md", md[2], 32'hA5A5A5A5);
    idle(2);

    // Reset two edges after a write acceptance aborts it
    step(1, 0, 1, 32'h10, 32'h99);
    idle(1);
    step(0, 0, 0, 32'h0, 32'h0);
    check("abort rdy",  32'(rdy[2]),  32'd0);
    check("abort busy", 32'(busy[2]), 32'd0);
    step(1, 0, 0, 32'h0, 32'h0);
    check("abort late rdy", 32'(rdy[2]), 32'd0);
    idle(3);
    step(1, 1, 0, 32'h10, 32'h0);
    idle(3);
    step(1, 0, 0, 32'h0, 32'h0);
    check("abort rd rdy", 32'(rdy[2]), 32'd1);
    check("abort rd md",  md[2],       32'h22);
    idle(2);

    // Out-of-range address 0x210 (WAIT_STATES=1)
    step(1, 0, 1, 32'h210, 32'h77);
    idle(1);
    step(1, 0, 0, 32'h0, 32'h0);
    check("oor wr rdy", 32'(rdy[1]), 32'd1);
    check("oor wr err", 32'(err[1]), 32'(ACHK));
    idle(2);
    step(1, 1, 0, 32'h010, 32'h0);
    idle(1);
    step(1, 0, 0, 32'h0, 32'h0);
    check("oor ram010", md[1], ACHK ? 32'h22 : 32'h77);
    check("oor rd010 err", 32'(err[1]), 32'd0);
    idle(2);
    step(1, 1, 0, 32'h210, 32'h0);
    idle(1);
    step(1, 0, 0, 32'h0, 32'h0);
    check("oor rd md",  md[1],       ACHK ? 32'h0 : 32'h77);
    check("oor rd err", 32'(err[1]), 32'(ACHK));
    idle(2);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] mar;
      mar = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) mar = mar | (32'd1 << $urandom_range(9, 31));
      step($urandom_range(0, 63) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           mar, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side responder for the datapath's memory interface: services the datapath's Read/Write strobes against the MAR address, returning read data on Mdatain.
- Single-port word-addressed RAM behind a small FSM with programmable wait states and a one-cycle completion pulse (MemReady).
- Replaces the bench-driven Mdatain stimulus in phase-3 integration.

Parameters:
- BITS, 32, data word width (matches datapath BITS).
- ADDR_BITS, 9, number of address bits decoded; memory depth 2**ADDR_BITS words.
- WAIT_STATES, 1, extra cycles between request acceptance and access (0..15).

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset; takes effect on the rising Clock edge where reset==0.
- Read  input  1  read request strobe from control unit.
- Write  input  1  write request strobe from control unit.
- MARVal  input  BITS  address from MAR; bits [ADDR_BITS-1:0] decoded.
- MDRVal  input  BITS  write data from MDR.
- Mdatain  output  BITS  read data to the MDR input mux.
- MemReady  output  1  one-cycle completion pulse (read or write).
- Busy  output  1  high while a transaction is pending.
- AddrErr  output  1  out-of-range flag (see Optional Feature).

Behaviour:
- Reset (reset==0 at an edge): state IDLE, Mdatain=0, MemReady=0, Busy=0, AddrErr=0, wait counter=0. RAM contents are not cleared. Reset mid-transaction aborts it; a pending write is not performed and no MemReady is issued.
- States: IDLE, WAIT, ACCESS.
- IDLE: at an edge with Read|Write high, capture MARVal[ADDR_BITS-1:0], MDRVal, and the op, then:
  - Busy<=1.
  - If WAIT_STATES==0, go to ACCESS; else go to WAIT with counter=WAIT_STATES-1.
- Read and Write both high is treated as a read; the write is dropped.
- WAIT: counter decrements each edge; when it is 0, go to ACCESS.
- ACCESS edge: perform the operation, MemReady<=1, Busy<=0, go to IDLE.
  - Read: Mdatain<=RAM[addr].
  - Write: RAM[addr]<=captured data.
- Latency: request accepted at edge k; access at edge k+WAIT_STATES+1. MemReady is high for exactly the following cycle. The earliest next acceptance is edge k+WAIT_STATES+2.
- MemReady deasserts at the next edge unconditionally.
- Strobes are ignored while Busy. Address and data are captured at acceptance; later changes have no effect.
- Strobes are level-sampled in IDLE. A strobe still high in the MemReady cycle starts a new transaction at that edge; the control unit must drop the strobe on MemReady.
- Mdatain holds the last read result; writes and idle cycles do not change it.
- Address bits above ADDR_BITS are ignored (address wraps modulo 2**ADDR_BITS) unless ADDR_CHECK_EN is defined.

Optional Feature:
- Macro: MEMORY_RESPONDER_ADDR_CHECK_EN.
- Defined: at acceptance, if any MARVal[BITS-1:ADDR_BITS] bit is 1, the transaction is flagged. At the ACCESS edge of a flagged transaction:
  - AddrErr<=1 for the MemReady cycle.
  - A flagged write is suppressed (RAM unchanged).
  - A flagged read returns Mdatain<=0.
  - Timing and MemReady are unchanged.
- Undefined: AddrErr is tied to 0 and addresses wrap as above.

Test Plan:
- Reset: hold reset=0 for 2 edges with Read=1 -> Mdatain=0, MemReady=0, Busy=0, no transaction started.
- Write then read, WAIT_STATES=1:
  - Write=1, MARVal=0x10, MDRVal=0x22 accepted at edge k -> Busy=1 for 2 cycles, MemReady pulse after edge k+2.
  - Read of 0x10 -> Mdatain=0x22 after its access edge, one MemReady pulse.
- WAIT_STATES=0, back-to-back reads of 0x10 and 0x11 (pre-written 0xA5A5A5A5), strobe dropped on MemReady:
  - MemReady after edges k+1 and k+3.
  - Mdatain=0x22 then 0xA5A5A5A5.
- Mid-transaction change and collision, WAIT_STATES=3:
  - Read of 0x10 accepted, then MARVal changed to 0x11 and Write pulsed while Busy -> returns 0x22; RAM[0x11] unchanged.
  - Read=Write=1 in IDLE -> read performed, no write.
- Reset during a pending write (WAIT_STATES=3), reset=0 at edge k+2 -> no MemReady; a later read of the address returns its old value.
- With MEMORY_RESPONDER_ADDR_CHECK_EN, WAIT_STATES=1:
  - Write to MARVal=0x210 -> AddrErr=1 with MemReady; RAM[0x010] unchanged.
  - Read of 0x210 -> Mdatain=0, AddrErr=1.
  - Without the macro, the same write lands at 0x010.
